// File: rtl/bp_sacc_io_arbiter_if.sv
// Handshake bundle between the sacc requesters, the shared I/O link and the arbiter.
// The arbiter connects through the master modport; the requester/link side uses slave.
interface bp_sacc_io_arbiter_if #(
  parameter int num_req_p    = 2,
  parameter int cmd_width_p  = 128,
  parameter int resp_width_p = 128
);
  logic [num_req_p*cmd_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0]             req_cmd_v_i;
  logic [num_req_p-1:0]             req_cmd_yumi_o;
  logic [resp_width_p-1:0]          req_resp_o;
  logic [num_req_p-1:0]             req_resp_v_o;
  logic [num_req_p-1:0]             req_resp_ready_i;
  logic [cmd_width_p-1:0]           io_cmd_o;
  logic                             io_cmd_v_o;
  logic                             io_cmd_ready_i;
  logic [resp_width_p-1:0]          io_resp_i;
  logic                             io_resp_v_i;
  logic                             io_resp_yumi_o;

  modport master (
    input  req_cmd_i, req_cmd_v_i, req_resp_ready_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
    output req_cmd_yumi_o, req_resp_o, req_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o
  );

  modport slave (
    output req_cmd_i, req_cmd_v_i, req_resp_ready_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
    input  req_cmd_yumi_o, req_resp_o, req_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o
  );
endinterface

// File: rtl/bp_sacc_io_arbiter.sv
// Round-robin arbiter sharing one I/O command/response channel among sacc requesters,
// with an in-order ID FIFO for response routing and per-requester credit limits.
module bp_sacc_io_arbiter #(
  parameter int num_req_p         = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int fifo_els_p        = 4,
  parameter int max_outstanding_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_sacc_io_arbiter_if.master        bus,
  output logic                        idle_o,
  output logic                        error_o
);

  localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int crd_w = $clog2(max_outstanding_p + 1);

  typedef logic [id_w-1:0] id_t;
  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e               state_r, state_n;
  id_t                  last_grant_r, held_r, rr_pick, sel, dest;
  logic                 rr_found, cmd_v, xfer, full, empty, push, pop;
  logic [num_req_p-1:0] elig, yumi, resp_v;
  logic [cmd_width_p-1:0] cmd_mux;
  id_t                  fifo_mem [2**ptr_w];
  logic [ptr_w-1:0]     wr_ptr_r, rd_ptr_r;
  logic [cnt_w-1:0]     count_r;
  logic [crd_w-1:0]     credit_r [num_req_p];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_r == cnt_w'(fifo_els_p));
  assign empty = (count_r == '0);
  assign dest  = fifo_mem[rd_ptr_r];

  always_comb begin
    elig = '0;
    for (int r = 0; r < num_req_p; r++)
      elig[r] = bus.req_cmd_v_i[r] & (credit_r[r] < crd_w'(max_outstanding_p)) & ~full;
  end

  // Priority is the circular distance from the requester after the last grant.
  always_comb begin
    int d, best_d;
    d       = 0;
    best_d  = num_req_p;
    rr_pick = '0;
    for (int r = 0; r < num_req_p; r++) begin
      d = (r + num_req_p - 1 - int'(last_grant_r)) % num_req_p;
      if (elig[r] && d < best_d) begin
        best_d  = d;
        rr_pick = id_t'(r);
      end
    end
  end

  assign rr_found = |elig;

  always_comb begin
    state_n = state_r;
    sel     = rr_pick;
    cmd_v   = 1'b0;
    case (state_r)
      UNLOCKED: begin
        cmd_v = rr_found;
        if (rr_found && !bus.io_cmd_ready_i) state_n = LOCKED;
      end
      LOCKED: begin
        sel   = held_r;
        cmd_v = 1'b1;
        if (bus.io_cmd_ready_i) state_n = UNLOCKED;
      end
      default: state_n = UNLOCKED;
    endcase
    if (!reset_n_i) cmd_v = 1'b0;
  end

  assign xfer = cmd_v & bus.io_cmd_ready_i;
  assign push = xfer;
  assign pop  = reset_n_i & bus.io_resp_v_i & ~empty & bus.req_resp_ready_i[dest];

  always_comb begin
    cmd_mux = '0;
    yumi    = '0;
    resp_v  = '0;
    for (int r = 0; r < num_req_p; r++) begin
      if (sel == id_t'(r)) cmd_mux = bus.req_cmd_i[r*cmd_width_p +: cmd_width_p];
      yumi[r]   = xfer & (sel == id_t'(r));
      resp_v[r] = reset_n_i & bus.io_resp_v_i & ~empty & (dest == id_t'(r));
    end
  end

  assign bus.io_cmd_o       = cmd_mux;
  assign bus.io_cmd_v_o     = cmd_v;
  assign bus.req_cmd_yumi_o = yumi;
  assign bus.req_resp_o     = bus.io_resp_i;
  assign bus.req_resp_v_o   = resp_v;
  // A response with nothing in flight is drained so the link cannot wedge.
  assign bus.io_resp_yumi_o = reset_n_i & bus.io_resp_v_i & (empty | bus.req_resp_ready_i[dest]);
  assign idle_o             = ~reset_n_i | (empty & ~|bus.req_cmd_v_i);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= UNLOCKED;
      last_grant_r <= id_t'(num_req_p - 1);
      held_r       <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      error_o      <= 1'b0;
      for (int r = 0; r < num_req_p; r++) credit_r[r] <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == UNLOCKED && state_n == LOCKED) held_r <= rr_pick;
      if (xfer) last_grant_r <= sel;
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
      if (bus.io_resp_v_i && empty) error_o <= 1'b1;
      for (int r = 0; r < num_req_p; r++)
        credit_r[r] <= credit_r[r] + crd_w'(push && (sel == id_t'(r)))
                                   - crd_w'(pop && (dest == id_t'(r)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_r] <= sel;
  end

endmodule

// File: tb/tb_bp_sacc_io_arbiter.sv
// Bench for bp_sacc_io_arbiter: vector table, directed corner sequences and a random run,
// all compared against a queue-based model of the arbitration and routing rules.
module tb_bp_sacc_io_arbiter;
  localparam int N  = 2;
  localparam int CW = 32;
  localparam int RW = 32;
  localparam int FE = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] cmds [N];
  logic [N-1:0]  req_v = '0;
  logic [N-1:0]  rready = '1;
  logic          io_rdy = 1'b0;
  logic          rv = 1'b0;
  logic [RW-1:0] rdata = '0;
  logic          idle, err;

  bp_sacc_io_arbiter_if #(.num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW)) bus ();

  bp_sacc_io_arbiter #(
    .num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW),
    .fifo_els_p(FE), .max_outstanding_p(MO)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus),
    .idle_o   (idle),
    .error_o  (err)
  );

  always_comb begin
    bus.req_cmd_i = '0;
    for (int r = 0; r < N; r++) bus.req_cmd_i[r*CW +: CW] = cmds[r];
  end
  assign bus.req_cmd_v_i      = req_v;
  assign bus.req_resp_ready_i = rready;
  assign bus.io_cmd_ready_i   = io_rdy;
  assign bus.io_resp_i        = rdata;
  assign bus.io_resp_v_i      = rv;

  // Reference model: in-flight IDs in issue order, credits per requester, lock flag.
  int   q[$];
  int   outst[N] = '{default: 0};
  int   lg = N - 1;
  bit   locked = 1'b0;
  int   held = 0;
  bit   m_err = 1'b0;

  int   n_chk = 0;
  int   n_fail = 0;
  logic [N-1:0] last_yumi = '0;
  bit   last_xfer = 1'b0;
  int   last_sel = 0;
  int   grants[$];

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic         rv;
    logic         cmd_v;
    logic [N-1:0] yumi;
    int           sel;
    logic         ryumi;
    logic         idle;
    logic         err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Called at a falling edge with inputs applied; checks, clocks, updates the model.
  task automatic tick();
    bit cv, xfer, hasr, ery, eidle, full;
    int sel, dest;
    logic [N-1:0] ey, erv;
    cv = 0; xfer = 0; hasr = 0; ery = 0; sel = 0; dest = 0; ey = '0; erv = '0;
    #1;
    if (rst_n) begin
      full = (q.size() == FE);
      if (locked) begin
        cv  = 1;
        sel = held;
      end else begin
        for (int i = 1; i <= N; i++) begin
          int r;
          r = (lg + i) % N;
          if (!cv && req_v[r] && outst[r] < MO && !full) begin
            cv  = 1;
            sel = r;
          end
        end
      end
      xfer = cv && io_rdy;
      if (xfer) ey[sel] = 1'b1;
      if (rv) begin
        if (q.size() > 0) begin
          hasr = 1;
          dest = q[0];
          erv[dest] = 1'b1;
          ery = rready[dest];
        end else begin
          ery = 1;
        end
      end
    end
    eidle = !rst_n || (q.size() == 0 && req_v == '0);
    chk("io_cmd_v", bus.io_cmd_v_o, cv);
    if (cv) chk("io_cmd", bus.io_cmd_o, cmds[sel]);
    chk("cmd_yumi", bus.req_cmd_yumi_o, ey);
    chk("resp_v", bus.req_resp_v_o, erv);
    if (hasr) chk("resp_data", bus.req_resp_o, rdata);
    chk("resp_yumi", bus.io_resp_yumi_o, ery);
    chk("idle", idle, eidle);
    chk("error", err, m_err);
    last_yumi = ey;
    last_xfer = xfer;
    last_sel  = sel;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      outst  = '{default: 0};
      lg     = N - 1;
      locked = 0;
      m_err  = 0;
    end else begin
      if (rv && !hasr) m_err = 1;
      if (hasr && ery) begin
        outst[dest]--;
        void'(q.pop_front());
      end
      if (xfer) begin
        q.push_back(sel);
        outst[sel]++;
        lg     = sel;
        locked = 0;
      end else if (cv) begin
        locked = 1;
        held   = sel;
      end
    end
    @(negedge clk);
  endtask

  // Requesters that were consumed get a fresh payload; keep=0 also drops their valid.
  task automatic refresh(input bit keep);
    for (int r = 0; r < N; r++)
      if (last_yumi[r]) begin
        cmds[r] = $urandom;
        if (!keep) req_v[r] = 1'b0;
      end
  endtask

  task automatic do_reset();
    rst_n = 0; req_v = '0; rv = 0; io_rdy = 0; rready = '1;
    tick();
    rst_n = 1;
  endtask

  initial begin
    for (int r = 0; r < N; r++) cmds[r] = $urandom;
    vecs[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 0, 1'b1, 1'b0, 1'b1};

    @(posedge clk);
    @(negedge clk);

    // Reset held with every requester asking.
    rst_n = 0; req_v = '1; io_rdy = 1;
    repeat (3) begin
      settle();
      chk("rst_yumi", bus.req_cmd_yumi_o, 2'b00);
      chk("rst_cmd_v", bus.io_cmd_v_o, 1'b0);
      chk("rst_idle", idle, 1'b1);
      tick();
    end

    // Single-cycle vectors from a fresh reset.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      for (int r = 0; r < N; r++) cmds[r] = $urandom;
      req_v = vecs[k].v; io_rdy = vecs[k].rdy; rv = vecs[k].rv; rready = '1; rdata = $urandom;
      settle();
      chk($sformatf("vec%0d_cmd_v", k), bus.io_cmd_v_o, vecs[k].cmd_v);
      chk($sformatf("vec%0d_yumi", k), bus.req_cmd_yumi_o, vecs[k].yumi);
      if (vecs[k].cmd_v) chk($sformatf("vec%0d_payload", k), bus.io_cmd_o, cmds[vecs[k].sel]);
      chk($sformatf("vec%0d_resp_yumi", k), bus.io_resp_yumi_o, vecs[k].ryumi);
      chk($sformatf("vec%0d_idle", k), idle, vecs[k].idle);
      tick();
      chk($sformatf("vec%0d_err", k), err, vecs[k].err);
    end

    // Round robin with prompt responses.
    do_reset();
    req_v = '1; io_rdy = 1; rready = '1;
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      rv = (q.size() > 0);
      rdata = $urandom;
      tick();
      if (last_xfer) grants.push_back(last_sel);
      refresh(1);
    end
    chk("rr_count", grants.size(), 8);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

    // Backpressure lock: req0 held while req1 arrives.
    do_reset();
    req_v = 2'b01; io_rdy = 0; rv = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) req_v = 2'b11;
      settle();
      chk("bp_payload", bus.io_cmd_o, cmds[0]);
      chk("bp_no_yumi", bus.req_cmd_yumi_o, 2'b00);
      tick();
    end
    io_rdy = 1;
    settle();
    chk("bp_payload_rdy", bus.io_cmd_o, cmds[0]);
    chk("bp_grant0", bus.req_cmd_yumi_o, 2'b01);
    tick();
    refresh(0);
    settle();
    chk("bp_grant1", bus.req_cmd_yumi_o, 2'b10);
    tick();
    refresh(0);

    // Credit limit on req0, req1 still served, release after one response.
    do_reset();
    req_v = 2'b01; io_rdy = 1; rv = 0; rready = '1;
    tick(); refresh(1);
    tick(); refresh(1);
    req_v = 2'b11;
    settle();
    chk("crd_req1", bus.req_cmd_yumi_o, 2'b10);
    tick(); refresh(0);
    rv = 1; rdata = $urandom;
    settle();
    chk("crd_blocked", bus.io_cmd_v_o, 1'b0);
    chk("crd_resp_dest", bus.req_resp_v_o, 2'b01);
    tick();
    rv = 0;
    settle();
    chk("crd_release", bus.req_cmd_yumi_o, 2'b01);
    tick(); refresh(0);

    // FIFO full, pop does not open a slot in the same cycle.
    do_reset();
    req_v = '1; io_rdy = 1; rv = 0;
    repeat (4) begin tick(); refresh(1); end
    settle();
    chk("full_cmd_v", bus.io_cmd_v_o, 1'b0);
    tick();
    rv = 1; rdata = $urandom;
    settle();
    chk("full_pop_cmd_v", bus.io_cmd_v_o, 1'b0);
    chk("full_pop_yumi", bus.io_resp_yumi_o, 1'b1);
    tick();
    rv = 0;
    settle();
    chk("full_next_issue", bus.req_cmd_yumi_o, 2'b01);
    tick(); refresh(0);
    req_v = '0;

    // Response stall, in-order drain, then an unexpected response.
    rv = 1; rready = '0;
    repeat (3) begin
      settle();
      chk("stall_yumi", bus.io_resp_yumi_o, 1'b0);
      chk("stall_head", bus.req_resp_v_o, 2'b10);
      tick();
    end
    rready = '1;
    for (int i = 0; i < 4; i++) begin
      rdata = $urandom;
      settle();
      chk($sformatf("drain_dest%0d", i), bus.req_resp_v_o, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    settle();
    chk("err_drain_yumi", bus.io_resp_yumi_o, 1'b1);
    chk("err_no_resp_v", bus.req_resp_v_o, 2'b00);
    tick();
    rv = 0;
    chk("err_set", err, 1'b1);
    tick(); tick();
    chk("err_sticky", err, 1'b1);
    rst_n = 0;
    tick();
    chk("err_cleared", err, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (last_yumi[r]) req_v[r] = 1'b0;
        if (!req_v[r] && $urandom_range(0, 1) == 1) begin
          req_v[r] = 1'b1;
          cmds[r]  = $urandom;
        end
      end
      io_rdy = ($urandom_range(0, 3) != 0);
      rv     = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      rdata  = $urandom;
      rready = N'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
